// File: rtl/aes_out_serializer_if.sv
// Bundle of the AES result input, the word stream output and the status
// signals of the AES output serializer. The master side is the environment
// (AES_top plus the consumer); the slave side is the serializer itself.
interface aes_out_serializer_if #(
  parameter int BLK_W  = 128,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) ();

  logic                       AES_data_out_valid;
  logic [BLK_W-1:0]           AES_data_out;
  logic                       ser_flush;
  logic [WORD_W-1:0]          ser_data;
  logic                       ser_valid;
  logic                       ser_ready;
  logic                       ser_last;
  logic [$clog2(DEPTH+1)-1:0] fifo_level;
  logic                       ser_overflow;
  logic [7:0]                 ser_drop_cnt;

  modport master (
    output AES_data_out_valid, AES_data_out, ser_flush, ser_ready,
    input  ser_data, ser_valid, ser_last, fifo_level, ser_overflow, ser_drop_cnt
  );

  modport slave (
    input  AES_data_out_valid, AES_data_out, ser_flush, ser_ready,
    output ser_data, ser_valid, ser_last, fifo_level, ser_overflow, ser_drop_cnt
  );

endinterface

// File: rtl/aes_out_serializer.sv
// AES output serializer: buffers each pulsed AES result in a DEPTH-entry
// block FIFO and streams it out MS word first on a valid/ready interface.
// Blocks arriving while the FIFO is full (and no pop is happening) are
// dropped, counted (saturating) and flagged by a sticky overflow bit.
module aes_out_serializer #(
  parameter int BLK_W  = 128,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                  AES_clk,
  input  logic                  AES_rst,
  aes_out_serializer_if.slave   bus
);

  localparam int NWORDS = BLK_W / WORD_W;
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW     = $clog2(DEPTH + 1);
  localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic [CW-1:0]      wcnt_q, wcnt_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         drop_q, drop_d;

  logic [BLK_W-1:0]   mem_q [DEPTH];
  logic [BLK_W-1:0]   head_d;

  logic               hs;
  logic               pop;
  logic               full;
  logic               wr;
  logic               drop;

  assign hs   = valid_q & bus.ser_ready;
  assign pop  = hs & last_q;
  assign full = (level_q == LW'(DEPTH));
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign wr   = bus.AES_data_out_valid & (~full | pop) & ~bus.ser_flush;
  assign drop = bus.AES_data_out_valid & full & ~pop & ~bus.ser_flush;

  // Next-state computation for pointers, counters, status and output word.
  always_comb begin
    wptr_d  = wr  ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
    level_d = level_q + LW'(wr) - LW'(pop);
    wcnt_d  = wcnt_q;
    if (pop) begin
      wcnt_d = '0;
    end else if (hs) begin
      wcnt_d = wcnt_q + CW'(1);
    end
    ovf_d  = ovf_q | drop;
    drop_d = (drop && (drop_q != '1)) ? drop_q + 8'd1 : drop_q;

    if (bus.ser_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      wcnt_d  = '0;
      ovf_d   = 1'b0;
      drop_d  = '0;
    end

    state_d = (level_d != '0) ? SEND : IDLE;

    // Outputs are registered, so the next head block is needed now. When the
    // block being written lands exactly at the next read slot it is the new
    // head and has to be forwarded because the memory only updates at the edge.
    head_d = (wr && (wptr_q == rptr_d)) ? bus.AES_data_out : mem_q[rptr_d];

    data_d  = '0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    if (state_d == SEND) begin
      valid_d = 1'b1;
      last_d  = (wcnt_d == CW'(NWORDS - 1));
      for (int unsigned i = 0; i < NWORDS; i++) begin
        if (wcnt_d == CW'(i)) begin
          data_d = head_d[BLK_W-1-i*WORD_W -: WORD_W];
        end
      end
    end
  end

  // Block storage; contents need no reset since level gates all reads.
  always_ff @(posedge AES_clk) begin
    if (wr) begin
      mem_q[wptr_q] <= bus.AES_data_out;
    end
  end

  // FSM, pointers, counters and registered outputs.
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      wcnt_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.ser_data     = data_q;
  assign bus.ser_valid    = valid_q;
  assign bus.ser_last     = last_q;
  assign bus.fifo_level   = level_q;
  assign bus.ser_overflow = ovf_q;
  assign bus.ser_drop_cnt = drop_q;

endmodule

// File: tb/tb_aes_out_serializer.sv
// Self-checking bench for aes_out_serializer: a directed vector table,
// hand-written corner-case sequences and a randomized phase, all compared
// cycle by cycle against a queue-based reference model.
module tb_aes_out_serializer;

  localparam int BLK_W  = 128;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 4;
  localparam int NW     = BLK_W / WORD_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  aes_out_serializer_if #(.BLK_W(BLK_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) bus ();

  aes_out_serializer #(.BLK_W(BLK_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .AES_clk (clk),
    .AES_rst (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [BLK_W-1:0]  mq[$];
  int                widx;
  int                mdrop;
  bit                movf;

  logic [WORD_W-1:0] got[$];

  typedef struct {
    logic              v;
    logic [BLK_W-1:0]  blk;
    logic              rdy;
    logic              exp_valid;
    logic [WORD_W-1:0] exp_data;
    logic              exp_last;
    logic [2:0]        exp_level;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [WORD_W-1:0] word_of(input logic [BLK_W-1:0] b, input int j);
    logic [BLK_W-1:0] s;
    s = b >> (WORD_W * (NW - 1 - j));
    return s[WORD_W-1:0];
  endfunction

  task automatic model_clear();
    mq.delete();
    widx  = 0;
    mdrop = 0;
    movf  = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [BLK_W-1:0] b, input logic fl, input logic rdy);
    bit popped;
    bit was_full;
    popped   = 1'b0;
    was_full = (mq.size() == DEPTH);
    if (fl) begin
      model_clear();
    end else begin
      if (mq.size() > 0 && rdy) begin
        if (widx == NW - 1) begin
          void'(mq.pop_front());
          widx   = 0;
          popped = 1'b1;
        end else begin
          widx++;
        end
      end
      if (v) begin
        if (!was_full || popped) begin
          mq.push_back(b);
        end else begin
          movf = 1'b1;
          if (mdrop < 255) mdrop++;
        end
      end
    end
  endtask

  task automatic model_check();
    logic [WORD_W-1:0] e_data;
    logic              e_valid;
    e_valid = (mq.size() > 0);
    e_data  = e_valid ? word_of(mq[0], widx) : '0;
    chk("valid",    BLK_W'(bus.ser_valid),    BLK_W'(e_valid));
    chk("data",     BLK_W'(bus.ser_data),     BLK_W'(e_data));
    chk("last",     BLK_W'(bus.ser_last),     BLK_W'(e_valid && widx == NW - 1));
    chk("level",    BLK_W'(bus.fifo_level),   BLK_W'(mq.size()));
    chk("overflow", BLK_W'(bus.ser_overflow), BLK_W'(movf));
    chk("drop_cnt", BLK_W'(bus.ser_drop_cnt), BLK_W'(mdrop));
  endtask

  // One clock cycle: apply inputs, record accepted words, advance model, compare.
  task automatic cyc(input logic v, input logic [BLK_W-1:0] b, input logic fl, input logic rdy);
    bus.AES_data_out_valid = v;
    bus.AES_data_out       = b;
    bus.ser_flush          = fl;
    bus.ser_ready          = rdy;
    if (bus.ser_valid && rdy) got.push_back(bus.ser_data);
    @(posedge clk);
    model_step(v, b, fl, rdy);
    #1;
    model_check();
  endtask

  localparam logic [BLK_W-1:0] B0 = 128'h3925841d_02dc09fb_dc118597_196a0b32;

  logic [BLK_W-1:0] blks[6];
  logic [BLK_W-1:0] bn;
  logic [BLK_W-1:0] rb;

  initial begin
    bus.AES_data_out_valid = 1'b0;
    bus.AES_data_out       = '0;
    bus.ser_flush          = 1'b0;
    bus.ser_ready          = 1'b0;
    model_clear();

    for (int i = 0; i < 6; i++) begin
      blks[i] = {32'(32'h1000_0000 + i), 32'(32'h2000_0000 + i),
                 32'(32'h3000_0000 + i), 32'(32'h4000_0000 + i)};
    end
    bn = 128'hcafef00d_deadbeef_01234567_89abcdef;

    // Test 1 as a vector table: one pulse, ready high, 4 consecutive words.
    tbl[0] = '{1'b1, B0,  1'b1, 1'b1, 32'h3925841d, 1'b0, 3'd1};
    tbl[1] = '{1'b0, '0,  1'b1, 1'b1, 32'h02dc09fb, 1'b0, 3'd1};
    tbl[2] = '{1'b0, '0,  1'b1, 1'b1, 32'hdc118597, 1'b0, 3'd1};
    tbl[3] = '{1'b0, '0,  1'b1, 1'b1, 32'h196a0b32, 1'b1, 3'd1};
    tbl[4] = '{1'b0, '0,  1'b1, 1'b0, 32'h0,        1'b0, 3'd0};

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", BLK_W'(bus.ser_valid),    '0);
    chk("rst_data",  BLK_W'(bus.ser_data),     '0);
    chk("rst_last",  BLK_W'(bus.ser_last),     '0);
    chk("rst_level", BLK_W'(bus.fifo_level),   '0);
    chk("rst_ovf",   BLK_W'(bus.ser_overflow), '0);
    chk("rst_drop",  BLK_W'(bus.ser_drop_cnt), '0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      cyc(tbl[i].v, tbl[i].blk, 1'b0, tbl[i].rdy);
      chk($sformatf("t1_valid%0d", i), BLK_W'(bus.ser_valid),  BLK_W'(tbl[i].exp_valid));
      chk($sformatf("t1_data%0d", i),  BLK_W'(bus.ser_data),   BLK_W'(tbl[i].exp_data));
      chk($sformatf("t1_last%0d", i),  BLK_W'(bus.ser_last),   BLK_W'(tbl[i].exp_last));
      chk($sformatf("t1_level%0d", i), BLK_W'(bus.fifo_level), BLK_W'(tbl[i].exp_level));
    end

    // Test 2: fill with ready low, 5th pulse dropped, then drain in order.
    got.delete();
    for (int i = 0; i < 4; i++) cyc(1'b1, blks[i], 1'b0, 1'b0);
    chk("t2_level4", BLK_W'(bus.fifo_level),   BLK_W'(4));
    chk("t2_noovf",  BLK_W'(bus.ser_overflow), '0);
    cyc(1'b1, blks[4], 1'b0, 1'b0);
    chk("t2_ovf",    BLK_W'(bus.ser_overflow), BLK_W'(1));
    chk("t2_drop1",  BLK_W'(bus.ser_drop_cnt), BLK_W'(1));
    chk("t2_level",  BLK_W'(bus.fifo_level),   BLK_W'(4));
    repeat (20) cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t2_nwords", BLK_W'(got.size()), BLK_W'(16));
    if (got.size() == 16) begin
      for (int i = 0; i < 16; i++)
        chk($sformatf("t2_word%0d", i), BLK_W'(got[i]), BLK_W'(word_of(blks[i / NW], i % NW)));
    end

    // Test 3: full FIFO, pulse on the last-word handshake of the head block.
    for (int i = 0; i < 4; i++) cyc(1'b1, blks[i], 1'b0, 1'b0);
    got.delete();
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, bn, 1'b0, 1'b1);
    chk("t3_level", BLK_W'(bus.fifo_level),   BLK_W'(4));
    chk("t3_drop",  BLK_W'(bus.ser_drop_cnt), BLK_W'(1));
    repeat (20) cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t3_nwords", BLK_W'(got.size()), BLK_W'(20));
    if (got.size() == 20) begin
      for (int j = 0; j < NW; j++)
        chk($sformatf("t3_lastblk%0d", j), BLK_W'(got[16 + j]), BLK_W'(word_of(bn, j)));
    end

    // Test 4: ready toggling during a block.
    got.delete();
    cyc(1'b1, blks[5], 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, '0, 1'b0, (i % 2) == 0);
    chk("t4_nwords", BLK_W'(got.size()), BLK_W'(4));
    if (got.size() == 4) begin
      for (int j = 0; j < NW; j++)
        chk($sformatf("t4_word%0d", j), BLK_W'(got[j]), BLK_W'(word_of(blks[5], j)));
    end

    // Test 5: async reset in the middle of a block.
    cyc(1'b1, B0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b1);
    bus.ser_ready = 1'b0;
    rst = 1'b1;
    #2;
    chk("t5_valid", BLK_W'(bus.ser_valid),  '0);
    chk("t5_data",  BLK_W'(bus.ser_data),   '0);
    chk("t5_last",  BLK_W'(bus.ser_last),   '0);
    chk("t5_level", BLK_W'(bus.fifo_level), '0);
    chk("t5_drop",  BLK_W'(bus.ser_drop_cnt), '0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, blks[2], 1'b0, 1'b0);
    chk("t5_word0", BLK_W'(bus.ser_data), BLK_W'(word_of(blks[2], 0)));
    repeat (8) cyc(1'b0, '0, 1'b0, 1'b1);

    // Test 6: flush with level 3 and two drops; pulse in flush cycle ignored.
    for (int i = 0; i < 6; i++) cyc(1'b1, blks[i], 1'b0, 1'b0);
    repeat (4) cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("t6_level3", BLK_W'(bus.fifo_level),   BLK_W'(3));
    chk("t6_drop2",  BLK_W'(bus.ser_drop_cnt), BLK_W'(2));
    cyc(1'b1, bn, 1'b1, 1'b0);
    chk("t6_level0", BLK_W'(bus.fifo_level),   '0);
    chk("t6_valid",  BLK_W'(bus.ser_valid),    '0);
    chk("t6_ovf",    BLK_W'(bus.ser_overflow), '0);
    chk("t6_drop0",  BLK_W'(bus.ser_drop_cnt), '0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t6_nostore", BLK_W'(bus.fifo_level), '0);

    // Randomized phase against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rb = {$urandom, $urandom, $urandom, $urandom};
      cyc($urandom_range(0, 2) == 0, rb, $urandom_range(0, 96) == 0, $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
